// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared types and constants for the sliced adder/subtractor
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Slice counter width; a single-slice configuration still needs one bit.
  function automatic int cnt_width(input int n_chunks);
    if (n_chunks <= 1) return 1;
    return $clog2(n_chunks);
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// rtl/adder_chunk.sv - CHUNK-bit ripple adder with carry-in built from full_adder cells
module adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign co = c[CHUNK];

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/addsub_seq_nbits.sv
// rtl/addsub_seq_nbits.sv - multi-cycle add/sub, one CHUNK-bit slice per clock
module addsub_seq_nbits
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] s_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             zero_o
);

  localparam int N_CHUNKS = WIDTH / CHUNK;
  localparam int CW = cnt_width(N_CHUNKS);
  localparam logic [CW-1:0] LAST = CW'(N_CHUNKS - 1);

  if (WIDTH % CHUNK != 0) begin : g_width_check
    $error("addsub_seq_nbits: WIDTH must be a multiple of CHUNK");
  end

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, s_q, s_nxt;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q, ovf_q, zero_q;
  logic [CHUNK-1:0] a_sl, b_sl, sum_sl;
  logic             c_sl;
  logic             accept, last;

  assign accept = in_valid_i && (state == IDLE);
  assign last   = (cnt_q == LAST);

  assign a_sl = a_q[int'(cnt_q)*CHUNK +: CHUNK];
  assign b_sl = b_q[int'(cnt_q)*CHUNK +: CHUNK];

  adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a  (a_sl),
    .b  (b_sl),
    .ci (carry_q),
    .s  (sum_sl),
    .co (c_sl)
  );

  // Result as it will look after this slice is written; zero flag is taken from it.
  always_comb begin
    s_nxt = s_q;
    s_nxt[int'(cnt_q)*CHUNK +: CHUNK] = sum_sl;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid_i)  state_nxt = RUN;
      RUN:     if (last)        state_nxt = DONE;
      DONE:    if (out_ready_i) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (state == IDLE);
    out_valid_o = (state == DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b1;
    end else if (accept) begin
      a_q     <= a_i;
      b_q     <= (sub_i == MODE_SUB) ? ~b_i : b_i;
      carry_q <= sub_i;
      cnt_q   <= '0;
    end else if (state == RUN) begin
      s_q     <= s_nxt;
      carry_q <= c_sl;
      cnt_q   <= last ? '0 : cnt_q + CW'(1);
      if (last) begin
        cout_q <= c_sl;
        // Same-sign operands (b already inverted for subtract) producing a different-sign result.
        ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_sl[CHUNK-1] != a_q[WIDTH-1]);
        zero_q <= ~|s_nxt;
      end
    end
  end

  assign s_o    = s_q;
  assign cout_o = cout_q;
  assign ovf_o  = ovf_q;
  assign zero_o = zero_q;

endmodule

// File: tb/tb_addsub_seq_nbits.sv
// tb/tb_addsub_seq_nbits.sv - self-checking bench for addsub_seq_nbits
module tb_addsub_seq_nbits;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        sub;
  logic        out_ready;
  logic [15:0] a, b;

  // index 0: CHUNK=1, index 1: CHUNK=4 (main), index 2: CHUNK=16
  logic        in_ready  [3];
  logic        out_valid [3];
  logic [15:0] s         [3];
  logic        cout      [3];
  logic        ovf       [3];
  logic        zero      [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  addsub_seq_nbits #(.WIDTH(16), .CHUNK(1)) u_c1 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready[0]),
    .sub_i(sub), .a_i(a), .b_i(b), .out_valid_o(out_valid[0]), .out_ready_i(out_ready),
    .s_o(s[0]), .cout_o(cout[0]), .ovf_o(ovf[0]), .zero_o(zero[0])
  );

  addsub_seq_nbits #(.WIDTH(16), .CHUNK(4)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready[1]),
    .sub_i(sub), .a_i(a), .b_i(b), .out_valid_o(out_valid[1]), .out_ready_i(out_ready),
    .s_o(s[1]), .cout_o(cout[1]), .ovf_o(ovf[1]), .zero_o(zero[1])
  );

  addsub_seq_nbits #(.WIDTH(16), .CHUNK(16)) u_c16 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready[2]),
    .sub_i(sub), .a_i(a), .b_i(b), .out_valid_o(out_valid[2]), .out_ready_i(out_ready),
    .s_o(s[2]), .cout_o(cout[2]), .ovf_o(ovf[2]), .zero_o(zero[2])
  );

  // Reference model in plain integer arithmetic.
  function automatic void model(input logic [15:0] ma, input logic [15:0] mb, input logic msub,
                                output logic [15:0] ms, output logic mc, output logic mv,
                                output logic mz);
    int sa, sb, r;
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    r  = msub ? sa - sb : sa + sb;
    mv = (r > 32767) || (r < -32768);
    ms = msub ? ma - mb : ma + mb;
    mc = msub ? (ma >= mb) : ((int'(ma) + int'(mb)) > 65535);
    mz = (ms == 16'h0000);
  endfunction

  function automatic int lat_of(input int idx);
    return (idx == 0) ? 16 : (idx == 1) ? 4 : 1;
  endfunction

  task automatic start_op(input logic [15:0] ta, input logic [15:0] tb, input logic tsub);
    int n;
    n = 0;
    while (!in_ready[1] && n < 50) begin
      @(posedge clk); #1; n++;
    end
    a = ta; b = tb; sub = tsub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid[1] && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic release_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; sub = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready[1], out_valid[1], s[1], cout[1], ovf[1], zero[1]} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: rdy=%0b vld=%0b s=%h c=%0b v=%0b z=%0b, want rdy=1 vld=0 s=0000 c=0 v=0 z=1",
               in_ready[1], out_valid[1], s[1], cout[1], ovf[1], zero[1]);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [15:0] va [5] = '{16'h1234, 16'h7FFF, 16'hFFFF, 16'h0005, 16'h8000};
    logic [15:0] vb [5] = '{16'h0FFF, 16'h0001, 16'h0001, 16'h0007, 16'h0001};
    logic        vs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] es [5] = '{16'h2233, 16'h8000, 16'h0000, 16'hFFFE, 16'h7FFF};
    logic        ec [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        ev [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        ez [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int lat;
    for (int i = 0; i < 5; i++) begin
      start_op(va[i], vb[i], vs[i]);
      wait_valid(lat);
      checks++;
      if (lat !== 4) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d cycles, want 4", i, lat);
      end
      checks++;
      if ({s[1], cout[1], ovf[1], zero[1]} !== {es[i], ec[i], ev[i], ez[i]}) begin
        errors++;
        $display("FAIL directed_result[%0d]: s=%h c=%0b v=%0b z=%0b, want s=%h c=%0b v=%0b z=%0b",
                 i, s[1], cout[1], ovf[1], zero[1], es[i], ec[i], ev[i], ez[i]);
      end
      release_op();
      checks++;
      if ({in_ready[1], out_valid[1]} !== 2'b10) begin
        errors++;
        $display("FAIL directed_release[%0d]: rdy=%0b vld=%0b, want rdy=1 vld=0", i, in_ready[1], out_valid[1]);
      end
    end
  endtask

  task automatic test_back_pressure();
    int lat;
    start_op(16'h4321, 16'h1111, 1'b0);
    // Pulse during RUN must be ignored.
    a = 16'hAAAA; b = 16'h5555; sub = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL bp_latency: got %0d further cycles, want 3", lat);
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = (i == 2);
      checks++;
      if ({out_valid[1], in_ready[1], s[1], cout[1], ovf[1], zero[1]} !== {1'b1, 1'b0, 16'h5432, 1'b0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: vld=%0b rdy=%0b s=%h c=%0b v=%0b z=%0b, want vld=1 rdy=0 s=5432 c=0 v=0 z=0",
                 i, out_valid[1], in_ready[1], s[1], cout[1], ovf[1], zero[1]);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    release_op();
    start_op(16'h0001, 16'h0002, 1'b1);
    wait_valid(lat);
    checks++;
    if ({lat == 4, s[1], cout[1], ovf[1], zero[1]} !== {1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL bp_next_op: lat=%0d s=%h c=%0b v=%0b z=%0b, want lat=4 s=ffff c=0 v=0 z=0",
               lat, s[1], cout[1], ovf[1], zero[1]);
    end
    release_op();
  endtask

  task automatic test_back_to_back();
    int t_valid [$];
    a = 16'h1111; b = 16'h2222; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && t_valid.size() < 3; cyc++) begin
      @(posedge clk); #1;
      if (out_valid[1]) begin
        t_valid.push_back(cyc);
        checks++;
        if (s[1] !== 16'h3333) begin
          errors++;
          $display("FAIL b2b_result: s=%h, want 3333", s[1]);
        end
        if (t_valid.size() == 3) in_valid = 1'b0;
      end
    end
    checks++;
    if (t_valid.size() != 3 || t_valid[1] - t_valid[0] != 6 || t_valid[2] - t_valid[1] != 6) begin
      errors++;
      $display("FAIL b2b_period: saw %0d results, periods %0d/%0d, want 3 results period 6",
               t_valid.size(), (t_valid.size() > 1) ? t_valid[1] - t_valid[0] : -1,
               (t_valid.size() > 2) ? t_valid[2] - t_valid[1] : -1);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    int lat;
    start_op(16'hFFFF, 16'h0001, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready[1], out_valid[1], s[1], cout[1], ovf[1], zero[1]} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid_op: rdy=%0b vld=%0b s=%h c=%0b v=%0b z=%0b, want rdy=1 vld=0 s=0000 c=0 v=0 z=1",
               in_ready[1], out_valid[1], s[1], cout[1], ovf[1], zero[1]);
    end
    @(negedge clk) rst_n = 1'b1;
    start_op(16'h0001, 16'h0001, 1'b0);
    wait_valid(lat);
    checks++;
    if ({lat == 4, s[1], cout[1], ovf[1], zero[1]} !== {1'b1, 16'h0002, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL after_reset_op: lat=%0d s=%h c=%0b v=%0b z=%0b, want lat=4 s=0002 c=0 v=0 z=0",
               lat, s[1], cout[1], ovf[1], zero[1]);
    end
    release_op();
  endtask

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'h7FFF;
      2:       return 16'h8000;
      3:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic test_sweep();
    logic [15:0] ms;
    logic        mc, mv, mz;
    logic [2:0]  seen;
    int          n;
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    for (int op = 0; op < 1000; op++) begin
      n = 0;
      while (!(in_ready[0] && in_ready[1] && in_ready[2]) && n < 40) begin
        @(posedge clk); #1; n++;
      end
      a = pick_operand(); b = pick_operand(); sub = 1'($urandom);
      model(a, b, sub, ms, mc, mv, mz);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      seen = 3'b000;
      n = 0;
      while (seen != 3'b111 && n < 30) begin
        @(posedge clk); #1; n++;
        for (int i = 0; i < 3; i++) begin
          if (out_valid[i] && !seen[i]) begin
            seen[i] = 1'b1;
            checks++;
            if (n !== lat_of(i)) begin
              errors++;
              $display("FAIL sweep_latency[op %0d dut %0d]: got %0d, want %0d", op, i, n, lat_of(i));
            end
            checks++;
            if ({s[i], cout[i], ovf[i], zero[i]} !== {ms, mc, mv, mz}) begin
              errors++;
              $display("FAIL sweep_result[op %0d dut %0d]: %h %s %h gave s=%h c=%0b v=%0b z=%0b, want s=%h c=%0b v=%0b z=%0b",
                       op, i, a, sub ? "-" : "+", b, s[i], cout[i], ovf[i], zero[i], ms, mc, mv, mz);
            end
          end
        end
      end
      if (seen != 3'b111) begin
        checks++;
        errors++;
        $display("FAIL sweep_timeout[op %0d]: results seen mask %b, want 111", op, seen);
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_pressure();
    test_back_to_back();
    test_reset_mid_op();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
